// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman round controller: state encoding,
// default sizing constants and counter widths.
package hangman_pkg;

    localparam int DEF_MAX_WORD  = 31;
    localparam int DEF_MAX_PARTS = 9;
    localparam int DEF_DP_LAT    = 1;
    localparam int DEF_SCORE_W   = 4;

    localparam int WL_W    = 5;
    localparam int PART_W  = 4;
    localparam int STATE_W = 4;

    typedef enum logic [3:0] {
        S_LOAD  = 4'd0,
        S_DASH  = 4'd1,
        S_GUESS = 4'd2,
        S_WAIT  = 4'd3,
        S_FILL  = 4'd4,
        S_CHECK = 4'd5,
        S_PART  = 4'd6,
        S_P1WIN = 4'd7,
        S_P2WIN = 4'd8,
        S_DONE  = 4'd9
    } state_e;

endpackage

// File: rtl/hangman_edge_pulse.sv
// Rising-edge one-shot. The history register is set on reset so a key that
// is already held when reset releases does not produce a pulse.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic hist_q, hist_d;
    logic pulse_q, pulse_d;

    // Next-state: remember the level, flag a low-to-high transition
    always_comb begin
        hist_d  = din;
        pulse_d = din & ~hist_q;
    end

    // History and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/hangman_control.sv
// Round-sequencing FSM for the hangman datapath: word entry, guessing,
// drawing strobes, part/length counters and per-player scores.
// Optional feature macro: HANGMAN_TIMEOUT_EN (guess timer ends the round
// in player 1's favour when defined; timeout is ignored otherwise).
module hangman_control
    import hangman_pkg::*;
#(
    parameter int MAX_WORD  = DEF_MAX_WORD,
    parameter int MAX_PARTS = DEF_MAX_PARTS,
    parameter int DP_LAT    = DEF_DP_LAT,
    parameter int SCORE_W   = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enter,
    input  logic               start_guess,
    input  logic               match,
    input  logic [4:0]         remain,
    input  logic               draw_done,
    input  logic               timeout,
    output logic               load,
    output logic               compare,
    output logic               draw_dash,
    output logic               draw_part,
    output logic               fill,
    output logic [4:0]         wordlength,
    output logic [3:0]         part,
    output logic [SCORE_W-1:0] p1score,
    output logic [SCORE_W-1:0] p2score,
    output logic               round_over,
    output logic [3:0]         state
);

    localparam int LAT_W = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic ent_p_s, sg_p_s;

    state_e              state_q, state_d;
    logic [WL_W-1:0]     wordlength_q, wordlength_d;
    logic [PART_W-1:0]   part_q, part_d;
    logic [SCORE_W-1:0]  p1score_q, p1score_d, p2score_q, p2score_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                load_q, load_d, compare_q, compare_d;
    logic                draw_dash_q, draw_dash_d, draw_part_q, draw_part_d;
    logic                fill_q, fill_d, round_over_q, round_over_d;
    logic                timeout_s;

    edge_pulse u_ent_edge (.clk(clk), .rst(resetn), .din(enter),       .pulse(ent_p_s));
    edge_pulse u_sg_edge  (.clk(clk), .rst(resetn), .din(start_guess), .pulse(sg_p_s));

`ifdef HANGMAN_TIMEOUT_EN
    assign timeout_s = timeout;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = timeout;
    assign timeout_s        = 1'b0;
`endif

    // Next-state, counter/score updates and registered-output next values
    always_comb begin
        state_d      = state_q;
        wordlength_d = wordlength_q;
        part_d       = part_q;
        p1score_d    = p1score_q;
        p2score_d    = p2score_q;
        lat_cnt_d    = lat_cnt_q;
        load_d       = 1'b0;
        compare_d    = 1'b0;
        case (state_q)
            S_LOAD: begin
                // start_guess beats a simultaneous enter; no load in that cycle
                if (sg_p_s) begin
                    if (wordlength_q != {WL_W{1'b0}}) begin
                        state_d = S_DASH;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (ent_p_s && (wordlength_q < WL_W'(MAX_WORD))) begin
                    load_d       = 1'b1;
                    wordlength_d = wordlength_q + WL_W'(1);
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DASH: begin
                if (draw_done) state_d = S_GUESS;
                else           state_d = S_DASH;
            end
            S_GUESS: begin
                if (timeout_s) begin
                    state_d = S_P1WIN;
                end else if (ent_p_s) begin
                    compare_d = 1'b1;
                    lat_cnt_d = {LAT_W{1'b0}};
                    state_d   = S_WAIT;
                end else begin
                    state_d = S_GUESS;
                end
            end
            S_WAIT: begin
                // match is only trusted DP_LAT cycles after the compare strobe
                if (lat_cnt_q == LAT_W'(DP_LAT)) begin
                    if (match) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_PART;
                        part_d  = part_q + PART_W'(1);
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_FILL: begin
                if (draw_done) state_d = S_CHECK;
                else           state_d = S_FILL;
            end
            S_CHECK: begin
                if (remain == 5'd0) state_d = S_P2WIN;
                else                state_d = S_GUESS;
            end
            S_PART: begin
                if (!draw_done)                         state_d = S_PART;
                else if (part_q == PART_W'(MAX_PARTS))  state_d = S_P1WIN;
                else                                    state_d = S_GUESS;
            end
            S_P1WIN: begin
                if (p1score_q != SCORE_MAX) p1score_d = p1score_q + SCORE_W'(1);
                else                        p1score_d = p1score_q;
                state_d = S_DONE;
            end
            S_P2WIN: begin
                if (p2score_q != SCORE_MAX) p2score_d = p2score_q + SCORE_W'(1);
                else                        p2score_d = p2score_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (ent_p_s) begin
                    wordlength_d = {WL_W{1'b0}};
                    part_d       = {PART_W{1'b0}};
                    state_d      = S_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        // Level outputs track the state being entered so they are registered
        draw_dash_d  = (state_d == S_DASH);
        draw_part_d  = (state_d == S_PART);
        fill_d       = (state_d == S_FILL);
        round_over_d = (state_d == S_DONE);
    end

    // State, counters, scores and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= S_LOAD;
            wordlength_q <= {WL_W{1'b0}};
            part_q       <= {PART_W{1'b0}};
            p1score_q    <= {SCORE_W{1'b0}};
            p2score_q    <= {SCORE_W{1'b0}};
            lat_cnt_q    <= {LAT_W{1'b0}};
            load_q       <= 1'b0;
            compare_q    <= 1'b0;
            draw_dash_q  <= 1'b0;
            draw_part_q  <= 1'b0;
            fill_q       <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wordlength_q <= wordlength_d;
            part_q       <= part_d;
            p1score_q    <= p1score_d;
            p2score_q    <= p2score_d;
            lat_cnt_q    <= lat_cnt_d;
            load_q       <= load_d;
            compare_q    <= compare_d;
            draw_dash_q  <= draw_dash_d;
            draw_part_q  <= draw_part_d;
            fill_q       <= fill_d;
            round_over_q <= round_over_d;
        end
    end

    assign load       = load_q;
    assign compare    = compare_q;
    assign draw_dash  = draw_dash_q;
    assign draw_part  = draw_part_q;
    assign fill       = fill_q;
    assign wordlength = wordlength_q;
    assign part       = part_q;
    assign p1score    = p1score_q;
    assign p2score    = p2score_q;
    assign round_over = round_over_q;
    assign state      = state_q;

endmodule
